// File: rtl/buzz_pattern_ctrl.sv
// Turns lock events into timed buzz_en envelopes and tracks consecutive password failures.
// Outputs are registered and react on the edge that samples an event; there is no backpressure.
module buzz_pattern_ctrl #(
    parameter int TICK_DIV = 50000,
    parameter int BEEP_MS  = 100,
    parameter int GAP_MS   = 100,
    parameter int FAIL_MS  = 500,
    parameter int ALARM_MS = 10000,
    parameter int MAX_FAIL = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_pulse,
    input  logic       pass_ok,
    input  logic       pass_fail,
    input  logic       alarm_clr,
    output logic       buzz_en,
    output logic       alarm_active,
    output logic [3:0] fail_cnt
);

    localparam int MAX_A   = (BEEP_MS > GAP_MS) ? BEEP_MS : GAP_MS;
    localparam int MAX_B   = (FAIL_MS > ALARM_MS) ? FAIL_MS : ALARM_MS;
    localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MSW     = $clog2(MAX_LEN + 1);
    localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0]  PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [MSW-1:0] BEEP_L   = MSW'(BEEP_MS - 1);
    localparam logic [MSW-1:0] GAP_L    = MSW'(GAP_MS - 1);
    localparam logic [MSW-1:0] FAIL_L   = MSW'(FAIL_MS - 1);
    localparam logic [MSW-1:0] ALARM_L  = MSW'(ALARM_MS - 1);
    localparam logic [3:0]     FAIL_TOP = 4'(MAX_FAIL);

    typedef enum logic [2:0] {
        S_IDLE, S_CLICK, S_OK_ON1, S_OK_GAP, S_OK_ON2, S_FAIL_ON, S_ALARM
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  pre_q, pre_d;
    logic [MSW-1:0] ms_q, ms_d;
    logic [3:0]     fail_q, fail_d;
    logic           buzz_q, buzz_d;
    logic           alarm_q, alarm_d;
    logic [MSW-1:0] last_ms;
    logic           expired;
    logic           restart;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            ms_q    <= '0;
            fail_q  <= '0;
            buzz_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            ms_q    <= ms_d;
            fail_q  <= fail_d;
            buzz_q  <= buzz_d;
            alarm_q <= alarm_d;
        end
    end

    always_comb begin
        last_ms = '0;
        case (state_q)
            S_CLICK, S_OK_ON1, S_OK_ON2: last_ms = BEEP_L;
            S_OK_GAP:                    last_ms = GAP_L;
            S_FAIL_ON:                   last_ms = FAIL_L;
            S_ALARM:                     last_ms = ALARM_L;
            default:                     last_ms = '0;
        endcase
    end

    assign expired = (state_q != S_IDLE) && (pre_q == PRE_MAX) && (ms_q == last_ms);

    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        restart = 1'b0;
        // Events outrank timer expiry; ALARM only listens to alarm_clr.
        if (alarm_clr) begin
            fail_d  = '0;
            state_d = S_IDLE;
            restart = 1'b1;
        end else if (pass_fail && state_q != S_ALARM) begin
            restart = 1'b1;
            if (fail_q + 4'd1 == FAIL_TOP) begin
                fail_d  = FAIL_TOP;
                state_d = S_ALARM;
            end else begin
                fail_d  = fail_q + 4'd1;
                state_d = S_FAIL_ON;
            end
        end else if (pass_ok && state_q != S_ALARM) begin
            fail_d  = '0;
            state_d = S_OK_ON1;
            restart = 1'b1;
        end else if (key_pulse && state_q == S_IDLE) begin
            state_d = S_CLICK;
            restart = 1'b1;
        end else if (expired) begin
            restart = 1'b1;
            case (state_q)
                S_OK_ON1: state_d = S_OK_GAP;
                S_OK_GAP: state_d = S_OK_ON2;
                S_ALARM: begin
                    state_d = S_IDLE;
                    fail_d  = '0;
                end
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        pre_d = '0;
        ms_d  = '0;
        if (!restart && state_q != S_IDLE) begin
            if (pre_q == PRE_MAX) begin
                ms_d = ms_q + MSW'(1);
            end else begin
                pre_d = pre_q + PW'(1);
                ms_d  = ms_q;
            end
        end
    end

    always_comb begin
        buzz_d  = 1'b0;
        alarm_d = 1'b0;
        case (state_d)
            S_CLICK, S_OK_ON1, S_OK_ON2, S_FAIL_ON: buzz_d = 1'b1;
            S_ALARM: begin
                buzz_d  = 1'b1;
                alarm_d = 1'b1;
            end
            default: buzz_d = 1'b0;
        endcase
    end

    assign buzz_en      = buzz_q;
    assign alarm_active = alarm_q;
    assign fail_cnt     = fail_q;

endmodule
